// File: rtl/hier_cache_pkg.sv
// Shared types and helpers for the hierarchical cache controller.
package hier_cache_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    L1_WAIT  = 3'd1,
    L2_WAIT  = 3'd2,
    MEM_WAIT = 3'd3,
    FILL     = 3'd4,
    WR_WAIT  = 3'd5,
    RESP     = 3'd6
  } ctrl_state_e;

  typedef enum logic [1:0] {
    RL_L1  = 2'd0,
    RL_L2  = 2'd1,
    RL_MEM = 2'd2,
    RL_WR  = 2'd3
  } resp_level_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hier_cache_ctrl_lat_timer.sv
// Shared down-counting latency timer; done is high while the count sits at zero.
module lat_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/hier_cache_ctrl.sv
// Single-outstanding L1 -> L2 -> memory read sequencer with write-through writes.
// Optional response counters are built when HIER_CACHE_STATS_EN is defined.
//
// state    | meaning
// IDLE     | ready for a request
// L1_WAIT  | waiting L1_LAT for L1 hit/data
// L2_WAIT  | waiting L2_LAT for L2 hit/data
// MEM_WAIT | waiting MEM_LAT for memory data
// FILL     | one-cycle fill of upper levels with fetched data
// WR_WAIT  | write-through broadcast, waiting for the slowest level
// RESP     | response held until resp_ready
module hier_cache_ctrl
  import hier_cache_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int L1_LAT     = 3,
  parameter int L2_LAT     = 3,
  parameter int MEM_LAT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]  req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_SIZE-1:0]  resp_data,
  output logic [1:0]            resp_level,
  output logic [ADDR_WIDTH-1:0] lk_addr,
  output logic [WORD_SIZE-1:0]  lk_wdata,
  output logic                  lk_wr,
  output logic                  l1_en,
  output logic                  l2_en,
  output logic                  mem_en,
  input  logic                  l1_hit,
  input  logic [WORD_SIZE-1:0]  l1_rdata,
  input  logic                  l2_hit,
  input  logic [WORD_SIZE-1:0]  l2_rdata,
`ifdef HIER_CACHE_STATS_EN
  output logic [31:0]           stat_l1_hit,
  output logic [31:0]           stat_l2_hit,
  output logic [31:0]           stat_mem_rd,
  output logic [31:0]           stat_wr,
`endif
  input  logic [WORD_SIZE-1:0]  mem_rdata
);

  localparam int MAX_LAT = max3(L1_LAT, L2_LAT, MEM_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  ctrl_state_e      state;
  logic             fill_mem;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  // Timer loads on the same edge that raises the matching enable strobe.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          tmr_load = 1'b1;
          tmr_val  = req_wr ? CNT_W'(MAX_LAT) : CNT_W'(L1_LAT);
        end
      end
      L1_WAIT: begin
        if (tmr_done && !l1_hit) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(L2_LAT);
        end
      end
      L2_WAIT: begin
        if (tmr_done && !l2_hit) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(MEM_LAT);
        end
      end
      default: ;
    endcase
  end

  lat_timer #(.W(CNT_W)) u_lat_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_level <= '0;
      lk_addr    <= '0;
      lk_wdata   <= '0;
      lk_wr      <= 1'b0;
      l1_en      <= 1'b0;
      l2_en      <= 1'b0;
      mem_en     <= 1'b0;
      fill_mem   <= 1'b0;
    end else begin
      l1_en  <= 1'b0;
      l2_en  <= 1'b0;
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            lk_addr   <= req_addr;
            lk_wdata  <= req_data;
            lk_wr     <= req_wr;
            l1_en     <= 1'b1;
            if (req_wr) begin
              l2_en  <= 1'b1;
              mem_en <= 1'b1;
              state  <= WR_WAIT;
            end else begin
              state <= L1_WAIT;
            end
          end
        end
        L1_WAIT: begin
          if (tmr_done) begin
            if (l1_hit) begin
              resp_data  <= l1_rdata;
              resp_level <= RL_L1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              l2_en <= 1'b1;
              state <= L2_WAIT;
            end
          end
        end
        L2_WAIT: begin
          if (tmr_done) begin
            if (l2_hit) begin
              lk_wdata <= l2_rdata;
              lk_wr    <= 1'b1;
              l1_en    <= 1'b1;
              fill_mem <= 1'b0;
              state    <= FILL;
            end else begin
              mem_en <= 1'b1;
              state  <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (tmr_done) begin
            lk_wdata <= mem_rdata;
            lk_wr    <= 1'b1;
            l1_en    <= 1'b1;
            l2_en    <= 1'b1;
            fill_mem <= 1'b1;
            state    <= FILL;
          end
        end
        FILL: begin
          lk_wr      <= 1'b0;
          resp_data  <= lk_wdata;
          resp_level <= fill_mem ? RL_MEM : RL_L2;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        WR_WAIT: begin
          if (tmr_done) begin
            resp_data  <= lk_wdata;
            resp_level <= RL_WR;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            lk_wr      <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HIER_CACHE_STATS_EN
  // Saturating per-type counters, bumped on the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_l1_hit <= '0;
      stat_l2_hit <= '0;
      stat_mem_rd <= '0;
      stat_wr     <= '0;
    end else if (resp_valid && resp_ready) begin
      case (resp_level)
        RL_L1:   if (stat_l1_hit != '1) stat_l1_hit <= stat_l1_hit + 1'b1;
        RL_L2:   if (stat_l2_hit != '1) stat_l2_hit <= stat_l2_hit + 1'b1;
        RL_MEM:  if (stat_mem_rd != '1) stat_mem_rd <= stat_mem_rd + 1'b1;
        default: if (stat_wr != '1)     stat_wr     <= stat_wr + 1'b1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_hier_cache_ctrl.sv
// Self-checking bench for hier_cache_ctrl: vector table, corner sequences and random traffic.
module tb_hier_cache_ctrl;

  localparam int WS = 32;
  localparam int AW = 32;
  localparam int L1 = 3;
  localparam int L2 = 3;
  localparam int ML = 8;
  localparam int MAXL = (L1 > L2) ? ((L1 > ML) ? L1 : ML) : ((L2 > ML) ? L2 : ML);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [WS-1:0] req_data;
  logic          resp_valid, resp_ready;
  logic [WS-1:0] resp_data;
  logic [1:0]    resp_level;
  logic [AW-1:0] lk_addr;
  logic [WS-1:0] lk_wdata;
  logic          lk_wr, l1_en, l2_en, mem_en;
  logic          l1_hit, l2_hit;
  logic [WS-1:0] l1_rdata, l2_rdata, mem_rdata;
`ifdef HIER_CACHE_STATS_EN
  logic [31:0]   stat_l1_hit, stat_l2_hit, stat_mem_rd, stat_wr;
  int            exp_st [4];
`endif

  hier_cache_ctrl #(
    .WORD_SIZE(WS), .ADDR_WIDTH(AW), .L1_LAT(L1), .L2_LAT(L2), .MEM_LAT(ML)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_level(resp_level),
    .lk_addr(lk_addr), .lk_wdata(lk_wdata), .lk_wr(lk_wr),
    .l1_en(l1_en), .l2_en(l2_en), .mem_en(mem_en),
    .l1_hit(l1_hit), .l1_rdata(l1_rdata),
    .l2_hit(l2_hit), .l2_rdata(l2_rdata),
`ifdef HIER_CACHE_STATS_EN
    .stat_l1_hit(stat_l1_hit), .stat_l2_hit(stat_l2_hit),
    .stat_mem_rd(stat_mem_rd), .stat_wr(stat_wr),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scenario seen by the level models: which level hits and what each returns.
  int            sc_lvl = 0;
  logic [WS-1:0] sc_d1 = '0, sc_d2 = '0, sc_dm = '0;
  int            c1 = -1, c2 = -1, c3 = -1;

  // Level models: valid hit/data only LAT cycles after a read strobe, noise otherwise.
  initial begin
    l1_hit = 1'b0; l2_hit = 1'b0;
    l1_rdata = '0; l2_rdata = '0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      c1 = (c1 > 0) ? c1 - 1 : -1;
      c2 = (c2 > 0) ? c2 - 1 : -1;
      c3 = (c3 > 0) ? c3 - 1 : -1;
      if (rst) begin
        c1 = -1; c2 = -1; c3 = -1;
      end else begin
        if (l1_en && !lk_wr) c1 = L1;
        if (l2_en && !lk_wr) c2 = L2;
        if (mem_en && !lk_wr) c3 = ML;
      end
      l1_hit    = (c1 == 0) ? (sc_lvl == 0) : 1'($urandom);
      l1_rdata  = (c1 == 0) ? sc_d1 : $urandom;
      l2_hit    = (c2 == 0) ? (sc_lvl == 1) : 1'($urandom);
      l2_rdata  = (c2 == 0) ? sc_d2 : $urandom;
      mem_rdata = (c3 == 0) ? sc_dm : $urandom;
    end
  end

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [WS-1:0] wdata;
    int            lvl;
    logic [WS-1:0] d1, d2, dm;
    int            hold;
    bit            busy_valid;
    int            exp_level;
    logic [WS-1:0] exp_data;
    int            exp_lat;
  } vec_t;

  // Reference model from the controller's observable rules.
  function automatic int ref_lat(input bit wr, input int lvl);
    if (wr) return MAXL + 2;
    case (lvl)
      0:       return L1 + 2;
      1:       return L1 + L2 + 4;
      default: return L1 + L2 + ML + 5;
    endcase
  endfunction

  function automatic logic [WS-1:0] ref_data(input vec_t v);
    if (v.wr) return v.wdata;
    return (v.lvl == 0) ? v.d1 : (v.lvl == 1) ? v.d2 : v.dm;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int lat, e1, e2, e3, rdy_busy, guard;
    logic [WS-1:0] fill;
    sc_lvl = v.lvl; sc_d1 = v.d1; sc_d2 = v.d2; sc_dm = v.dm;
    fill = (v.lvl == 1) ? v.d2 : v.dm;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk); guard++;
    end
    if (guard >= 100) chk({tag, "_ready_timeout"}, 0, 1);
    req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_data = v.wdata;
    @(negedge clk);
    lat = 1; e1 = 0; e2 = 0; e3 = 0; rdy_busy = 0;
    if (!v.busy_valid) req_valid = 1'b0;
    chk({tag, "_accepted"}, req_ready, 0);
    while (!resp_valid && lat < 200) begin
      if (l1_en) e1++;
      if (l2_en) e2++;
      if (mem_en) e3++;
      if (req_ready) rdy_busy++;
      if (!v.wr && l1_en && !lk_wr)
        chk({tag, "_l1en_cycle_addr"}, {lat[7:0], lk_addr}, {8'd1, v.addr});
      if (!v.wr && l1_en && lk_wr)
        chk({tag, "_fill"}, {l2_en, mem_en, lk_wdata}, {v.lvl == 2, 1'b0, fill});
      if (v.wr && l1_en)
        chk({tag, "_wr_bcast"}, {lat[7:0], l2_en, mem_en, lk_wr, lk_addr, lk_wdata},
            {8'd1, 3'b111, v.addr, v.wdata});
      @(negedge clk); lat++;
    end
    req_valid = 1'b0;
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_resp"}, {resp_level, resp_data}, {v.exp_level[1:0], v.exp_data});
    chk({tag, "_enables"}, {e1[7:0], e2[7:0], e3[7:0], rdy_busy[7:0]},
        v.wr ? {8'd1, 8'd1, 8'd1, 8'd0} :
        (v.lvl == 0) ? {8'd1, 8'd0, 8'd0, 8'd0} :
        (v.lvl == 1) ? {8'd2, 8'd1, 8'd0, 8'd0} : {8'd2, 8'd2, 8'd1, 8'd0});
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {resp_valid, req_ready, resp_level, resp_data},
          {1'b1, 1'b0, v.exp_level[1:0], v.exp_data});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_released"}, {resp_valid, req_ready}, 2'b01);
`ifdef HIER_CACHE_STATS_EN
    exp_st[v.exp_level]++;
    case (v.exp_level)
      0:       chk({tag, "_stat_l1"},  stat_l1_hit, exp_st[0]);
      1:       chk({tag, "_stat_l2"},  stat_l2_hit, exp_st[1]);
      2:       chk({tag, "_stat_mem"}, stat_mem_rd, exp_st[2]);
      default: chk({tag, "_stat_wr"},  stat_wr,     exp_st[3]);
    endcase
`endif
  endtask

  task automatic reset_mid_mem();
    int bad;
    sc_lvl = 2; sc_d1 = $urandom; sc_d2 = $urandom; sc_dm = 32'h5555AAAA;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h700; req_data = '0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (L1 + L2 + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", {req_ready, resp_valid, l1_en, l2_en, mem_en, lk_wr, lk_addr},
        {6'b100000, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_outputs2", {req_ready, resp_valid, l1_en, l2_en, mem_en}, 5'b10000);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (resp_valid || l1_en || l2_en || mem_en || !req_ready) bad++;
    end
    chk("rst_no_late_activity", bad, 0);
  endtask

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0;
    resp_ready = 1'b0;
`ifdef HIER_CACHE_STATS_EN
    for (int i = 0; i < 4; i++) exp_st[i] = 0;
`endif
    tbl[0] = '{1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'h1, 32'h2, 0, 1'b0, 0, 32'hDEADBEEF, 5};
    tbl[1] = '{1'b0, 32'h204, 32'h0, 1, 32'h3, 32'hCAFE0001, 32'h4, 0, 1'b0, 1, 32'hCAFE0001, 10};
    tbl[2] = '{1'b0, 32'h308, 32'h0, 2, 32'h5, 32'h6, 32'h12345678, 0, 1'b0, 2, 32'h12345678, 19};
    tbl[3] = '{1'b1, 32'h40, 32'hA5A5A5A5, 0, 32'h7, 32'h8, 32'h9, 0, 1'b1, 3, 32'hA5A5A5A5, 10};
    tbl[4] = '{1'b0, 32'h500, 32'h0, 0, 32'h0BADF00D, 32'hA, 32'hB, 5, 1'b0, 0, 32'h0BADF00D, 5};
    tbl[5] = '{1'b0, 32'h60C, 32'h0, 2, 32'hC, 32'hD, 32'hFEEDF00D, 5, 1'b1, 2, 32'hFEEDF00D, 19};

    repeat (3) @(negedge clk);
    chk("reset_state", {req_ready, resp_valid, l1_en, l2_en, mem_en, lk_wr, resp_level, resp_data},
        {6'b100000, 2'b00, 32'h0});
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    reset_mid_mem();
`ifdef HIER_CACHE_STATS_EN
    for (int i = 0; i < 4; i++) exp_st[i] = 0;
    chk("stat_cleared", {stat_l1_hit, stat_mem_rd}, 64'h0);
`endif
    run_txn(tbl[0], "after_rst");

    for (int i = 0; i < 24; i++) begin
      v.wr         = ($urandom_range(0, 3) == 0);
      v.addr       = $urandom;
      v.wdata      = $urandom;
      v.lvl        = $urandom_range(0, 2);
      v.d1         = $urandom;
      v.d2         = $urandom;
      v.dm         = $urandom;
      v.hold       = $urandom_range(0, 3);
      v.busy_valid = $urandom_range(0, 1);
      v.exp_level  = v.wr ? 3 : v.lvl;
      v.exp_data   = ref_data(v);
      v.exp_lat    = ref_lat(v.wr, v.lvl);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
